ir_cmd_scheduler: RTL and testbench
===================================

Name: ir_cmd_scheduler

Overview:
- Sequences the output of the 32-bit NEC infrared frame decoder.
- Validates each decoded frame for address match and command/inverse check, then classifies it as a new key press or an auto-repeat.
- Issues the command to one downstream consumer over a valid/ready handshake.
- Tracks key hold and release with a timeout. Sits between the IR decoder and the application command logic.

Parameters:
- ADDR, 8'h00, expected device address, compared with frame_data[7:0].
- ADDR_CHECK, 1, 1: require address match and frame_data[15:8] == ~frame_data[7:0]. 0: ignore bits [15:0].
- HOLD_CYCLES, 6_000_000, key-held timeout in clk cycles (120 ms at 50 MHz).
- REPEAT_THRESH, 3, number of consecutive same-key frames before auto-repeat commands are issued.
- TIMER_W, 23, hold timer width. Must hold HOLD_CYCLES.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous active-high reset.
- frame_data  in  32  decoded frame. Fields: [7:0] address, [15:8] ~address, [23:16] command, [31:24] ~command.
- frame_valid  in  1  one-cycle pulse; frame_data is stable in that cycle.
- cmd_data  out  8  command code.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  consumer accepts the command.
- cmd_repeat  out  1  qualifies cmd_data: 1 = auto-repeat, 0 = fresh press.
- key_held  out  1  high while a valid key is considered pressed.
- key_release  out  1  one-cycle pulse when the hold timer expires.
- err_count  out  8  saturating count of rejected frames.
- overrun  out  1  sticky; a frame arrived while a command was pending.
- clr_status  in  1  clears err_count and overrun.

Behaviour:
- One clock domain, clk. All state resets synchronously on rst = 1.
- Reset values: cmd_data = 0, cmd_valid = 0, cmd_repeat = 0, key_held = 0, key_release = 0, err_count = 0, overrun = 0. State = IDLE, last_key = 0, rep_cnt = 0, hold timer = 0.
- A frame is captured into an internal latch on the frame_valid cycle in IDLE or HOLD.
- Validity check:
  - frame_data[31:24] == ~frame_data[23:16], and
  - if ADDR_CHECK = 1: frame_data[7:0] == ADDR and frame_data[15:8] == ~ADDR.
- State machine:
  - IDLE: on frame_valid, go to CHECK.
  - CHECK (exactly 1 cycle):
    - Invalid frame: err_count +1 (saturates at 255). Return to HOLD if key_held, else IDLE.
    - Valid and (key_held = 0 or key != last_key): last_key <= key, rep_cnt <= 1, hold timer <= HOLD_CYCLES, key_held <= 1. Load cmd_data = key, cmd_repeat = 0. Go to ISSUE.
    - Valid, key_held = 1, key == last_key: hold timer reloads; rep_cnt +1 (saturates at REPEAT_THRESH).
      - If the new rep_cnt >= REPEAT_THRESH: load cmd_data = key, cmd_repeat = 1, go to ISSUE.
      - Otherwise go to HOLD.
  - ISSUE: cmd_valid = 1. cmd_data and cmd_repeat stay stable until cmd_valid && cmd_ready; that cycle is the transfer. Next state is HOLD and cmd_valid is 0.
  - HOLD: the hold timer decrements every cycle.
    - frame_valid: go to CHECK.
    - Timer reaches 0: key_release = 1 for one cycle, key_held <= 0, go to IDLE.
- Latency: frame_valid at cycle N gives cmd_valid high at cycle N+2.
- frame_valid during CHECK or ISSUE: the frame is dropped and overrun <= 1. The hold timer still decrements during ISSUE.
- If the timer expires during ISSUE, the pending command still completes. Release is then signalled on the first HOLD cycle.
- A frame and timer expiry in the same HOLD cycle: the frame wins (timer reloads, no release).
- clr_status and an error in the same cycle: the clear wins.
- rst asserted mid-ISSUE drops the pending command. No transfer occurs in that cycle.

Decomposition:
- Shared package ir_pkg holds:
  - state encoding (IDLE, CHECK, ISSUE, HOLD, 2 bits);
  - field slice constants: ADDR_LSB = 0, NADDR_LSB = 8, CMD_LSB = 16, NCMD_LSB = 24;
  - CLK_HZ = 50_000_000.
- One sub-module is natural: ir_hold_timer (load, decrement, expire pulse).

Test Plan:
1. Valid frame 32'hEF10_FF00 (key 8'h10, ADDR 0), cmd_ready = 1.
   - Response: cmd_valid 2 cycles later, cmd_data = 8'h10, cmd_repeat = 0.
   - After HOLD_CYCLES: key_release pulse and key_held = 0.
2. Four identical frames, 100 ms apart.
   - Response: frames 1, 3 and 4 issue (1 fresh, 3–4 repeat). Frame 2 issues nothing. One release after the last frame.
3. Bad command inverse 32'h0010_FF00, then bad address with ADDR_CHECK = 1.
   - Response: no cmd_valid, err_count = 2. Then clr_status gives err_count = 0.
4. cmd_ready held 0 for 500 cycles with a second frame arriving meanwhile.
   - Response: cmd_data stable, overrun = 1, exactly one transfer when ready rises.
5. Key 8'h10 is held, then frame with key 8'h22.
   - Response: immediate fresh command 8'h22, cmd_repeat = 0, no release pulse in between.
6. rst pulsed while in ISSUE.
   - Response: next cycle all outputs at reset values. A subsequent valid frame is treated as a fresh press.

Source files
------------

// File: rtl/ir_pkg.sv
// Shared definitions for the NEC IR command scheduler: FSM states, frame
// field positions and the frame validity rule.
package ir_pkg;

   localparam int unsigned CLK_HZ    = 50_000_000;

   localparam int unsigned ADDR_LSB  = 0;
   localparam int unsigned NADDR_LSB = 8;
   localparam int unsigned CMD_LSB   = 16;
   localparam int unsigned NCMD_LSB  = 24;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ISSUE = 2'd2,
      HOLD  = 2'd3
   } ir_state_t;

   // Command must match its inverse; the address pair is only checked when enabled.
   function automatic logic frame_ok(input logic [31:0] frame,
                                     input logic [7:0]  addr,
                                     input logic        addr_check);
      logic [7:0] a;
      logic [7:0] na;
      logic [7:0] c;
      logic [7:0] nc;
      a  = frame[ADDR_LSB  +: 8];
      na = frame[NADDR_LSB +: 8];
      c  = frame[CMD_LSB   +: 8];
      nc = frame[NCMD_LSB  +: 8];
      return (nc == ~c) && (!addr_check || ((a == addr) && (na == ~addr)));
   endfunction

   function automatic logic [7:0] frame_key(input logic [31:0] frame);
      return frame[CMD_LSB +: 8];
   endfunction

endpackage

// File: rtl/ir_hold_timer.sv
// Key-hold timer: loads the hold period, counts down while enabled and
// reports expiry as a level once the count has reached zero.
module ir_hold_timer
   import ir_pkg::*;
#(
   parameter int unsigned TIMER_W     = 23,
   parameter int unsigned HOLD_CYCLES = CLK_HZ / 1000 * 120
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic dec,
   output logic expired
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= TIMER_W'(HOLD_CYCLES);
      end else if (dec && (count != '0)) begin
         count <= count - TIMER_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/ir_cmd_scheduler.sv
// Validates decoded NEC frames, classifies them as fresh presses or
// auto-repeats, and hands commands to one consumer over valid/ready.
module ir_cmd_scheduler
   import ir_pkg::*;
#(
   parameter logic [7:0]  ADDR          = 8'h00,
   parameter logic        ADDR_CHECK    = 1'b1,
   parameter int unsigned HOLD_CYCLES   = CLK_HZ / 1000 * 120,
   parameter int unsigned REPEAT_THRESH = 3,
   parameter int unsigned TIMER_W       = 23
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] frame_data,
   input  logic        frame_valid,
   output logic [7:0]  cmd_data,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic        cmd_repeat,
   output logic        key_held,
   output logic        key_release,
   output logic [7:0]  err_count,
   output logic        overrun,
   input  logic        clr_status
);

   localparam int unsigned         REP_W   = $clog2(REPEAT_THRESH + 1);
   localparam logic [REP_W-1:0]    REP_MAX = REP_W'(REPEAT_THRESH);

   ir_state_t          state;
   ir_state_t          state_nxt;
   logic [31:0]        frame_q;
   logic [7:0]         last_key;
   logic [REP_W-1:0]   rep_cnt;
   logic [REP_W-1:0]   rep_inc;
   logic [7:0]         key;
   logic               frame_good;
   logic               same_key;
   logic               fire_rep;
   logic               capture;
   logic               drop;
   logic               release_now;
   logic               timer_load;
   logic               timer_dec;
   logic               timer_expired;

   ir_hold_timer #(
      .TIMER_W     (TIMER_W),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (timer_load),
      .dec     (timer_dec),
      .expired (timer_expired)
   );

   assign key        = frame_key(frame_q);
   assign frame_good = frame_ok(frame_q, ADDR, ADDR_CHECK);
   assign same_key   = key_held && (key == last_key);
   assign rep_inc    = (rep_cnt >= REP_MAX) ? rep_cnt : rep_cnt + REP_W'(1);
   assign fire_rep   = (rep_inc >= REP_MAX);

   assign capture     = frame_valid && ((state == IDLE) || (state == HOLD));
   assign drop        = frame_valid && ((state == CHECK) || (state == ISSUE));
   // A frame arriving on the expiry cycle takes priority over the release.
   assign release_now = (state == HOLD) && !frame_valid && timer_expired;

   // Gated by rst so a pending command cannot transfer in the reset cycle.
   assign cmd_valid = (state == ISSUE) && !rst;

   always_comb begin
      state_nxt  = state;
      timer_load = 1'b0;
      timer_dec  = 1'b0;
      unique case (state)
         IDLE: begin
            if (frame_valid) state_nxt = CHECK;
         end
         CHECK: begin
            if (!frame_good) begin
               state_nxt = key_held ? HOLD : IDLE;
            end else begin
               timer_load = 1'b1;
               state_nxt  = (!same_key || fire_rep) ? ISSUE : HOLD;
            end
         end
         ISSUE: begin
            timer_dec = 1'b1;
            if (cmd_ready) state_nxt = HOLD;
         end
         HOLD: begin
            timer_dec = 1'b1;
            if (frame_valid)        state_nxt = CHECK;
            else if (timer_expired) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q <= '0;
      end else if (capture) begin
         frame_q <= frame_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_key    <= '0;
         rep_cnt     <= '0;
         key_held    <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_release <= release_now;
         if ((state == CHECK) && frame_good) begin
            last_key <= key;
            key_held <= 1'b1;
            rep_cnt  <= same_key ? rep_inc : REP_W'(1);
         end else if (release_now) begin
            key_held <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_data   <= '0;
         cmd_repeat <= 1'b0;
      end else if ((state == CHECK) && frame_good) begin
         if (!same_key) begin
            cmd_data   <= key;
            cmd_repeat <= 1'b0;
         end else if (fire_rep) begin
            cmd_data   <= key;
            cmd_repeat <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
         overrun   <= 1'b0;
      end else if (clr_status) begin
         err_count <= '0;
         overrun   <= 1'b0;
      end else begin
         if ((state == CHECK) && !frame_good && (err_count != '1)) begin
            err_count <= err_count + 8'd1;
         end
         if (drop) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Self-checking bench for ir_cmd_scheduler: directed scenarios followed by a
// randomized frame stream checked against a transaction-level key model.
module tb_ir_cmd_scheduler;

   localparam int unsigned H = 200;

   logic        clk         = 1'b0;
   logic        rst         = 1'b1;
   logic [31:0] frame_data  = '0;
   logic        frame_valid = 1'b0;
   logic        clr_status  = 1'b0;
   logic        cmd_ready   = 1'b1;
   logic [7:0]  cmd_data;
   logic        cmd_valid;
   logic        cmd_repeat;
   logic        key_held;
   logic        key_release;
   logic [7:0]  err_count;
   logic        overrun;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;
   int unsigned last_fv = 0;
   int unsigned rel_cnt = 0;
   int unsigned rel_cyc = 0;
   bit          ready_mode  = 1'b0;
   logic        ready_force = 1'b1;
   logic [8:0]  xfer_q[$];
   logic        prev_stall = 1'b0;
   logic        prev_rel   = 1'b0;
   logic [8:0]  prev_cmd   = '0;

   ir_cmd_scheduler #(
      .ADDR          (8'h00),
      .ADDR_CHECK    (1'b1),
      .HOLD_CYCLES   (H),
      .REPEAT_THRESH (3),
      .TIMER_W       (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .cmd_data    (cmd_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_repeat  (cmd_repeat),
      .key_held    (key_held),
      .key_release (key_release),
      .err_count   (err_count),
      .overrun     (overrun),
      .clr_status  (clr_status)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #2;
      cmd_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transfer log, release counter and handshake stability monitor.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
         prev_rel   = 1'b0;
      end else begin
         if (prev_stall) begin
            check_eq("stall_valid", cmd_valid, 1);
            check_eq("stall_data", {cmd_repeat, cmd_data}, prev_cmd);
         end
         if (cmd_valid && cmd_ready) xfer_q.push_back({cmd_repeat, cmd_data});
         if (key_release) begin
            rel_cnt++;
            rel_cyc = cyc;
            check_eq("rel_width", prev_rel, 0);
         end
         prev_stall = cmd_valid && !cmd_ready;
         prev_cmd   = {cmd_repeat, cmd_data};
         prev_rel   = key_release;
      end
   end

   function automatic logic [31:0] mk(input logic [7:0] k);
      return {~k, k, 8'hFF, 8'h00};
   endfunction

   task automatic expect_xfer(input string tag, input logic [8:0] word);
      for (int i = 0; i < 200 && xfer_q.size() == 0; i++) @(posedge clk);
      check_eq({tag, "_cnt"}, xfer_q.size(), 1);
      if (xfer_q.size() != 0) check_eq(tag, xfer_q.pop_front(), word);
   endtask

   task automatic pulse_frame(input logic [31:0] f);
      @(posedge clk); #1;
      frame_data  = f;
      frame_valid = 1'b1;
      last_fv     = cyc;
      @(posedge clk); #1;
      frame_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] f, input bit exp_cmd,
                             input logic [8:0] word, input bit wait_xfer);
      pulse_frame(f);
      @(negedge clk);
      check_eq("lat_check", cmd_valid, 0);
      @(negedge clk);
      check_eq("lat_issue", cmd_valid, exp_cmd);
      if (exp_cmd && wait_xfer) begin
         expect_xfer("xfer", word);
      end else if (!exp_cmd) begin
         repeat (3) @(posedge clk);
         check_eq("no_xfer", xfer_q.size(), 0);
      end
   endtask

   task automatic pulse_clr();
      @(posedge clk); #1;
      clr_status = 1'b1;
      @(posedge clk); #1;
      clr_status = 1'b0;
   endtask

   task automatic wait_rel(input string tag, input int unsigned target);
      for (int i = 0; i < H + 100 && rel_cnt < target; i++) @(posedge clk);
      check_eq(tag, rel_cnt, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, cmd_valid, 0);
      check_eq({tag, "_data"}, cmd_data, 0);
      check_eq({tag, "_repeat"}, cmd_repeat, 0);
      check_eq({tag, "_held"}, key_held, 0);
      check_eq({tag, "_release"}, key_release, 0);
      check_eq({tag, "_err"}, err_count, 0);
      check_eq({tag, "_overrun"}, overrun, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

   initial begin
      int unsigned t, d, r0, rel_exp, m_err, m_rep, t_reload;
      bit          m_held, valid, exp_cmd, exp_rep;
      logic [7:0]  m_last, k, nk, a, na, flip;
      logic [7:0]  keys[4];
      keys = '{8'h10, 8'h22, 8'h5A, 8'hA5};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Single fresh press, then release after the hold period
      send_frame(32'hEF10_FF00, 1, {1'b0, 8'h10}, 1);
      t = last_fv;
      check_eq("t1_held", key_held, 1);
      wait_rel("t1_rel", 1);
      d = rel_cyc - t;
      check_eq("t1_rel_time", (d >= H + 2) && (d <= H + 3), 1);
      @(negedge clk);
      check_eq("t1_released", key_held, 0);

      // Four identical frames: fresh, silent, repeat, repeat
      r0 = rel_cnt;
      for (int i = 0; i < 4; i++) begin
         send_frame(mk(8'h10), i != 1, {(i >= 2), 8'h10}, 1);
         if (i < 3) repeat (95) @(posedge clk);
      end
      check_eq("t2_no_early_rel", rel_cnt, r0);
      wait_rel("t2_rel", r0 + 1);

      // Rejected frames, status clear, and clear winning over an error
      send_frame(32'h0010_FF00, 0, '0, 1);
      send_frame(32'hEF10_FE01, 0, '0, 1);
      check_eq("t3_err", err_count, 2);
      check_eq("t3_held", key_held, 0);
      pulse_clr();
      @(negedge clk);
      check_eq("t3_clr", err_count, 0);
      pulse_frame(32'h0010_FF00);
      clr_status = 1'b1;
      @(posedge clk); #1;
      clr_status = 1'b0;
      @(negedge clk);
      check_eq("t3_clr_wins", err_count, 0);

      // Back-pressure with an overrunning frame; timer expires during ISSUE
      ready_force = 1'b0;
      r0 = rel_cnt;
      send_frame(mk(8'h33), 1, {1'b0, 8'h33}, 0);
      repeat (100) @(posedge clk);
      pulse_frame(mk(8'h44));
      repeat (400) @(posedge clk);
      @(negedge clk);
      check_eq("t4_valid", cmd_valid, 1);
      check_eq("t4_data", cmd_data, 8'h33);
      check_eq("t4_overrun", overrun, 1);
      check_eq("t4_no_xfer", xfer_q.size(), 0);
      ready_force = 1'b1;
      expect_xfer("t4_xfer", {1'b0, 8'h33});
      repeat (20) @(posedge clk);
      check_eq("t4_single", xfer_q.size(), 0);
      wait_rel("t4_rel", r0 + 1);
      pulse_clr();
      @(negedge clk);
      check_eq("t4_ovr_clr", overrun, 0);

      // Frame colliding with expiry, then a different key while held
      r0 = rel_cnt;
      send_frame(mk(8'h10), 1, {1'b0, 8'h10}, 1);
      t = last_fv;
      while (cyc < t + H + 1) begin
         @(posedge clk); #1;
      end
      send_frame(mk(8'h10), 0, '0, 1);
      check_eq("t5_collide_held", key_held, 1);
      repeat (50) @(posedge clk);
      send_frame(mk(8'h22), 1, {1'b0, 8'h22}, 1);
      check_eq("t5_no_rel", rel_cnt, r0);
      check_eq("t5_held", key_held, 1);

      // Reset while a repeat command is pending
      repeat (20) @(posedge clk);
      send_frame(mk(8'h22), 0, '0, 1);
      repeat (20) @(posedge clk);
      ready_force = 1'b0;
      send_frame(mk(8'h22), 1, {1'b1, 8'h22}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      ready_force = 1'b1;
      @(negedge clk);
      check_eq("t6_rst_gate", cmd_valid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("t6");
      check_eq("t6_no_xfer", xfer_q.size(), 0);
      send_frame(mk(8'h22), 1, {1'b0, 8'h22}, 1);

      // Randomized frame stream against the key-press model
      repeat (H + 30) @(posedge clk);
      pulse_clr();
      ready_mode = 1'b1;
      r0 = rel_cnt;
      rel_exp = 0;
      m_err = 0;
      m_rep = 0;
      m_held = 1'b0;
      m_last = '0;
      t_reload = cyc;
      for (int n = 0; n < 60; n++) begin
         if (m_held && ($urandom_range(0, 2) != 0) && (cyc - t_reload < 120)) begin
            repeat ($urandom_range(5, 30)) @(posedge clk);
         end else if (m_held) begin
            while (cyc - t_reload < H + 20) @(posedge clk);
            m_held = 1'b0;
            rel_exp++;
            check_eq("rand_released", key_held, 0);
         end else begin
            repeat ($urandom_range(5, 30)) @(posedge clk);
         end
         k  = keys[$urandom_range(0, 3)];
         nk = ~k;
         a  = 8'h00;
         na = 8'hFF;
         if ($urandom_range(0, 4) == 0) begin
            flip = 8'($urandom_range(1, 255));
            case ($urandom_range(0, 2))
               0:       nk = nk ^ flip;
               1:       a  = a ^ flip;
               default: na = na ^ flip;
            endcase
         end
         valid   = (nk == ~k) && (a == 8'h00) && (na == 8'hFF);
         exp_cmd = 1'b0;
         exp_rep = 1'b0;
         if (!valid) begin
            if (m_err < 255) m_err++;
         end else if (!m_held || (k != m_last)) begin
            m_held  = 1'b1;
            m_last  = k;
            m_rep   = 1;
            exp_cmd = 1'b1;
         end else begin
            if (m_rep < 3) m_rep++;
            exp_cmd = (m_rep >= 3);
            exp_rep = 1'b1;
         end
         send_frame({nk, k, na, a}, exp_cmd, {exp_rep, k}, 1);
         if (valid) t_reload = last_fv;
      end
      ready_mode = 1'b0;
      repeat (H + 30) @(posedge clk);
      if (m_held) rel_exp++;
      @(negedge clk);
      check_eq("rand_rel_count", rel_cnt - r0, rel_exp);
      check_eq("rand_err", err_count, m_err);
      check_eq("rand_overrun", overrun, 0);
      check_eq("rand_held_end", key_held, 0);
      check_eq("rand_leftover", xfer_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
